except_detect_ex: RTL and testbench

Parametrised EX-stage exception detector with an integrated EX/MEM exception register. It merges ALU overflow and conditional-trap causes into the incoming exception vector and registers the result toward MEM with stall and flush control. It holds a sticky pending state that squashes younger instructions until the pipeline flush arrives. Optional saturating cause counters support performance and debug visibility.

---
 rtl/except_detect_ex.sv | 138 +++++++++++++
 tb/tb_except_detect_ex.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_detect_ex.sv
// EX-stage exception detector: merges overflow/trap causes, registers toward MEM, squashes while pending.
// Optional saturating cause counters built when EXCEPT_CNT_EN is defined.
module except_detect_ex #(
  parameter int EXC_W    = 32,
  parameter int OV_BIT   = 10,
  parameter int TRAP_BIT = 11,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             alu_lf,
  input  logic             alu_of,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             trap,
  input  logic             overflow_detect,
  input  logic [2:0]       condition,
  input  logic [EXC_W-1:0] excepttype_in,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [EXC_W-1:0] excepttype_out,
  output logic             exc_pending,
  output logic [CNT_W-1:0] ov_count,
  output logic [CNT_W-1:0] trap_count
);

  localparam int STAGES = 1;

  typedef enum logic {IDLE, PENDING} state_t;

  typedef struct packed {
    logic lf;
    logic of;
    logic zf;
    logic cf;
  } alu_flags_t;

  alu_flags_t           flags;
  state_t               state, state_nx;
  logic [STAGES:0]      vld_pipe;
  logic                 vld_nx;
  logic [EXC_W-1:0]     exc_q, exc_nx;
  logic                 cond_true, take_trap, take_ov;
  logic [EXC_W-1:0]     next_exc;
  logic                 cap_evt;

  assign flags = '{lf: alu_lf, of: alu_of, zf: alu_zf, cf: alu_cf};

  always_comb begin
    cond_true = 1'b0;
    case (condition)
      3'b001:  cond_true =  flags.zf;
      3'b010:  cond_true = !flags.zf;
      3'b011:  cond_true = !flags.lf;
      3'b110:  cond_true =  flags.lf;
      3'b100:  cond_true = !flags.cf;
      3'b101:  cond_true =  flags.cf;
      default: cond_true = 1'b0;
    endcase
  end

  assign take_trap = trap & cond_true;
  assign take_ov   = overflow_detect & flags.of;
  assign next_exc  = excepttype_in
                   | (EXC_W'(take_ov)   << OV_BIT)
                   | (EXC_W'(take_trap) << TRAP_BIT);

  assign vld_pipe[0] = in_valid;

  // Flush beats stall beats capture; PENDING turns every capture into a bubble.
  always_comb begin
    state_nx = state;
    vld_nx   = vld_pipe[STAGES];
    exc_nx   = exc_q;
    cap_evt  = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      vld_nx   = 1'b0;
      exc_nx   = '0;
    end else if (!stall) begin
      if (state == IDLE) begin
        vld_nx  = in_valid;
        exc_nx  = in_valid ? next_exc : '0;
        cap_evt = in_valid;
        if (in_valid && (next_exc != '0))
          state_nx = PENDING;
      end else begin
        vld_nx = 1'b0;
        exc_nx = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      vld_pipe[STAGES:1] <= '0;
      exc_q              <= '0;
    end else begin
      state              <= state_nx;
      vld_pipe[STAGES:1] <= vld_nx;
      exc_q              <= exc_nx;
    end
  end

  assign out_valid      = vld_pipe[STAGES];
  assign excepttype_out = exc_q;
  assign exc_pending    = (state == PENDING);

`ifdef EXCEPT_CNT_EN
  logic [CNT_W-1:0] ov_cnt, trap_cnt;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      ov_cnt   <= '0;
      trap_cnt <= '0;
    end else if (cap_evt) begin
      if (take_ov && (ov_cnt != '1))
        ov_cnt <= ov_cnt + 1'b1;
      if (take_trap && (trap_cnt != '1))
        trap_cnt <= trap_cnt + 1'b1;
    end
  end

  assign ov_count   = ov_cnt;
  assign trap_count = trap_cnt;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, cap_evt};
  assign ov_count   = '0;
  assign trap_count = '0;
`endif

endmodule

// File: tb/tb_except_detect_ex.sv
// Directed-vector bench for except_detect_ex (counters checked at CNT_W=4 when EXCEPT_CNT_EN is set).
module tb_except_detect_ex;

  localparam int EXC_W = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, stall, flush;
  logic             alu_lf, alu_of, alu_zf, alu_cf;
  logic             trap, overflow_detect;
  logic [2:0]       condition;
  logic [EXC_W-1:0] excepttype_in;
  logic             cnt_clr;
  logic             out_valid;
  logic [EXC_W-1:0] excepttype_out;
  logic             exc_pending;
  logic [CNT_W-1:0] ov_count, trap_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  except_detect_ex #(.EXC_W(EXC_W), .OV_BIT(10), .TRAP_BIT(11), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_lf(alu_lf), .alu_of(alu_of), .alu_zf(alu_zf), .alu_cf(alu_cf),
    .trap(trap), .overflow_detect(overflow_detect), .condition(condition),
    .excepttype_in(excepttype_in), .cnt_clr(cnt_clr), .out_valid(out_valid),
    .excepttype_out(excepttype_out), .exc_pending(exc_pending),
    .ov_count(ov_count), .trap_count(trap_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0; cnt_clr = 0;
    alu_lf = 0; alu_of = 0; alu_zf = 0; alu_cf = 0;
    trap = 0; overflow_detect = 0; condition = 3'b000; excepttype_in = '0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    checks++;
    if (out_valid !== 1'b0 || excepttype_out !== '0 || exc_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b exc=%h p=%b want 0 0 0", out_valid, excepttype_out, exc_pending);
    end
    checks++;
    if (ov_count !== '0 || trap_count !== '0) begin
      errors++;
      $display("FAIL reset_counters: got ov=%0d tr=%0d want 0 0", ov_count, trap_count);
    end
  endtask

  task automatic test_overflow();
    idle_inputs();
    in_valid = 1; overflow_detect = 1; alu_of = 1;
    step();
    idle_inputs();
    checks++;
    if (excepttype_out !== 32'h400 || out_valid !== 1'b1 || exc_pending !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got exc=%h v=%b p=%b want 400 1 1", excepttype_out, out_valid, exc_pending);
    end
    checks++;
`ifdef EXCEPT_CNT_EN
    if (ov_count !== 4'd1 || trap_count !== 4'd0) begin
      errors++;
      $display("FAIL overflow_count: got ov=%0d tr=%0d want 1 0", ov_count, trap_count);
    end
`else
    if (ov_count !== 4'd0 || trap_count !== 4'd0) begin
      errors++;
      $display("FAIL overflow_count: got ov=%0d tr=%0d want 0 0", ov_count, trap_count);
    end
`endif
    do_flush();
    checks++;
    if (exc_pending !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flush: got p=%b v=%b want 0 0", exc_pending, out_valid);
    end
    // overflow_detect without alu_of is clean
    idle_inputs();
    in_valid = 1; overflow_detect = 1;
    step();
    idle_inputs();
    checks++;
    if (excepttype_out !== '0 || out_valid !== 1'b1 || exc_pending !== 1'b0) begin
      errors++;
      $display("FAIL ov_not_set: got exc=%h v=%b p=%b want 0 1 0", excepttype_out, out_valid, exc_pending);
    end
  endtask

  task automatic test_cond_sweep();
    // bit f of each mask: trap taken for flags {lf,zf,cf} == f
    logic [7:0] taken_tbl [8];
    logic [EXC_W-1:0] exp_exc;
    taken_tbl[0] = 8'h00; taken_tbl[1] = 8'hCC; taken_tbl[2] = 8'h33; taken_tbl[3] = 8'h0F;
    taken_tbl[4] = 8'h55; taken_tbl[5] = 8'hAA; taken_tbl[6] = 8'hF0; taken_tbl[7] = 8'h00;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [7:0] m;
        logic [2:0] fl;
        m  = taken_tbl[c];
        fl = 3'(f);
        idle_inputs();
        in_valid = 1; trap = 1; condition = 3'(c);
        alu_lf = fl[2]; alu_zf = fl[1]; alu_cf = fl[0];
        excepttype_in = (f % 2 == 1) ? 32'h1 : 32'h0;
        exp_exc = excepttype_in | (m[f] ? 32'h800 : 32'h0);
        step();
        idle_inputs();
        checks++;
        if (excepttype_out !== exp_exc || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL cond_sweep c=%0d f=%0d: got exc=%h v=%b want %h 1", c, f, excepttype_out, out_valid, exp_exc);
        end
        do_flush();
      end
    end
  endtask

  task automatic test_combined();
    idle_inputs();
    in_valid = 1; overflow_detect = 1; alu_of = 1; trap = 1; condition = 3'b001; alu_zf = 1;
    excepttype_in = 32'h4;
    step();
    idle_inputs();
    checks++;
    if (excepttype_out !== 32'hC04 || out_valid !== 1'b1 || exc_pending !== 1'b1) begin
      errors++;
      $display("FAIL combined: got exc=%h v=%b p=%b want c04 1 1", excepttype_out, out_valid, exc_pending);
    end
    do_flush();
  endtask

  task automatic test_squash_flush();
    idle_inputs();
    in_valid = 1; overflow_detect = 1; alu_of = 1;
    step();
    checks++;
    if (excepttype_out !== 32'h400 || exc_pending !== 1'b1) begin
      errors++;
      $display("FAIL squash_enter: got exc=%h p=%b want 400 1", excepttype_out, exc_pending);
    end
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      in_valid = 1; excepttype_in = '0;
      step();
      checks++;
      if (out_valid !== 1'b0 || excepttype_out !== '0 || exc_pending !== 1'b1) begin
        errors++;
        $display("FAIL squash_bubble%0d: got v=%b exc=%h p=%b want 0 0 1", i, out_valid, excepttype_out, exc_pending);
      end
    end
    idle_inputs();
    in_valid = 1; flush = 1; overflow_detect = 1; alu_of = 1;
    step();
    checks++;
    if (out_valid !== 1'b0 || excepttype_out !== '0 || exc_pending !== 1'b0) begin
      errors++;
      $display("FAIL squash_flush: got v=%b exc=%h p=%b want 0 0 0", out_valid, excepttype_out, exc_pending);
    end
    idle_inputs();
    in_valid = 1; excepttype_in = '0;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || excepttype_out !== '0 || exc_pending !== 1'b0) begin
      errors++;
      $display("FAIL squash_resume: got v=%b exc=%h p=%b want 1 0 0", out_valid, excepttype_out, exc_pending);
    end
  endtask

  task automatic test_stall_flush_reset();
    idle_inputs();
    in_valid = 1; trap = 1; condition = 3'b101; alu_cf = 1;
    step();
    checks++;
    if (excepttype_out !== 32'h800 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_load: got exc=%h v=%b want 800 1", excepttype_out, out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      stall = 1; in_valid = 1; excepttype_in = 32'h5;
      step();
      checks++;
      if (excepttype_out !== 32'h800 || out_valid !== 1'b1 || exc_pending !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got exc=%h v=%b p=%b want 800 1 1", i, excepttype_out, out_valid, exc_pending);
      end
    end
    idle_inputs();
    stall = 1; flush = 1; in_valid = 1; excepttype_in = 32'h5;
    step();
    checks++;
    if (excepttype_out !== '0 || out_valid !== 1'b0 || exc_pending !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: got exc=%h v=%b p=%b want 0 0 0", excepttype_out, out_valid, exc_pending);
    end
    idle_inputs();
    in_valid = 1; excepttype_in = 32'h2;
    step();
    checks++;
    if (excepttype_out !== 32'h2 || exc_pending !== 1'b1) begin
      errors++;
      $display("FAIL rst_enter: got exc=%h p=%b want 2 1", excepttype_out, exc_pending);
    end
    idle_inputs();
    in_valid = 1; overflow_detect = 1; alu_of = 1;
    rst_n = 0;
    step();
    rst_n = 1;
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || excepttype_out !== '0 || exc_pending !== 1'b0 ||
        ov_count !== '0 || trap_count !== '0) begin
      errors++;
      $display("FAIL rst_pending: got v=%b exc=%h p=%b ov=%0d tr=%0d want all 0",
               out_valid, excepttype_out, exc_pending, ov_count, trap_count);
    end
  endtask

  task automatic test_counters();
    idle_inputs();
    cnt_clr = 1;
    step();
    for (int i = 0; i < 17; i++) begin
      idle_inputs();
      in_valid = 1; overflow_detect = 1; alu_of = 1;
      step();
      do_flush();
    end
    checks++;
`ifdef EXCEPT_CNT_EN
    if (ov_count !== 4'd15 || trap_count !== 4'd0) begin
      errors++;
      $display("FAIL cnt_saturate: got ov=%0d tr=%0d want 15 0", ov_count, trap_count);
    end
`else
    if (ov_count !== 4'd0 || trap_count !== 4'd0) begin
      errors++;
      $display("FAIL cnt_saturate: got ov=%0d tr=%0d want 0 0", ov_count, trap_count);
    end
`endif
    idle_inputs();
    in_valid = 1; overflow_detect = 1; alu_of = 1; trap = 1; condition = 3'b010; cnt_clr = 1;
    step();
    checks++;
    if (ov_count !== 4'd0 || trap_count !== 4'd0 || excepttype_out !== 32'hC00) begin
      errors++;
      $display("FAIL cnt_clr_wins: got ov=%0d tr=%0d exc=%h want 0 0 c00", ov_count, trap_count, excepttype_out);
    end
    do_flush();
    idle_inputs();
    in_valid = 1; trap = 1; condition = 3'b011;
    step();
    do_flush();
    checks++;
`ifdef EXCEPT_CNT_EN
    if (trap_count !== 4'd1 || ov_count !== 4'd0) begin
      errors++;
      $display("FAIL cnt_trap: got ov=%0d tr=%0d want 0 1", ov_count, trap_count);
    end
`else
    if (trap_count !== 4'd0 || ov_count !== 4'd0) begin
      errors++;
      $display("FAIL cnt_trap: got ov=%0d tr=%0d want 0 0", ov_count, trap_count);
    end
`endif
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_overflow();
    test_cond_sweep();
    test_combined();
    test_squash_flush();
    test_stall_flush_reset();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
